// File: rtl/nonce_sequencer_pkg.sv
// Shared definitions for the nonce sequencer: default widths, the WAIT
// timeout, FSM state encoding and a saturating counter helper.
package nonce_sequencer_pkg;

  localparam int NONCE_W_DEF = 32;
  localparam int HASH_W_DEF  = 24;
  localparam int TIMEOUT_DEF = 64;

  // state  | meaning
  // IDLE   | waiting for start; result flags hold
  // ISSUE  | presenting cur to the hash core
  // WAIT   | nonce accepted, waiting for the hash (timeout armed)
  // CHECK  | one-cycle compare against target / limit
  // DONE   | search finished, busy drops; back to IDLE
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nonce_sequencer_if.sv
// Nonce/hash handshake between the sequencer (master) and the hash core
// (slave).
//   nonce, nonce_valid : candidate offered by the sequencer
//   hash_ready         : core accepts the candidate
//   hash_in, hash_valid: single-cycle hash result from the core
interface nonce_sequencer_if
  import nonce_sequencer_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF
) ();

  logic [NONCE_W-1:0] nonce;
  logic               nonce_valid;
  logic               hash_ready;
  logic [HASH_W-1:0]  hash_in;
  logic               hash_valid;

  modport master (
    output nonce, nonce_valid,
    input  hash_ready, hash_in, hash_valid
  );

  modport slave (
    input  nonce, nonce_valid,
    output hash_ready, hash_in, hash_valid
  );

endinterface

// File: rtl/nonce_timeout_counter.sv
// Clearable up-counter with a terminal-count flag at TIMEOUT-1.
//   clk, reset : clock, synchronous active-high reset
//   clear      : return count to 0 (takes priority over enable)
//   enable     : advance by one
//   tc         : count == TIMEOUT-1
module nonce_timeout_counter
  import nonce_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/nonce_sequencer.sv
// Sequences candidate nonces into the hash core, compares each hash with
// the programmed target and stops on the first hit or when limit nonces
// have been tried.
//   clk, reset                : clock, synchronous active-high reset
//   start, seed, limit, target: search request (sampled on start in IDLE)
//   bus                       : nonce/hash handshake to the core
//   busy, fin, exhausted      : search status
//   found_nonce, attempts     : winning nonce, hashes evaluated
//   retries                   : WAIT timeouts (saturating)
module nonce_sequencer
  import nonce_sequencer_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NONCE_W-1:0] seed,
  input  logic [NONCE_W-1:0] limit,
  input  logic [HASH_W-1:0]  target,
  nonce_sequencer_if.master  bus,
  output logic               busy,
  output logic               fin,
  output logic               exhausted,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [NONCE_W-1:0] attempts,
  output logic [7:0]         retries
);

  logic [2:0]         state;
  logic [NONCE_W-1:0] cur;
  logic [NONCE_W-1:0] limit_reg;
  logic [HASH_W-1:0]  target_reg;
  logic [HASH_W-1:0]  hash_reg;
  logic [NONCE_W-1:0] attempts_next;
  logic               timeout_tc;

  assign attempts_next = attempts + NONCE_W'(1);

  nonce_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state == S_ISSUE && bus.hash_ready),
    .enable(state == S_WAIT),
    .tc    (timeout_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      limit_reg   <= '0;
      target_reg  <= '0;
      hash_reg    <= '0;
      attempts    <= '0;
      retries     <= '0;
      fin         <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur        <= seed;
            limit_reg  <= limit;
            target_reg <= target;
            attempts   <= '0;
            retries    <= '0;
            fin        <= 1'b0;
            exhausted  <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.hash_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          // a hash arriving on the timeout cycle is still accepted
          if (bus.hash_valid) begin
            hash_reg <= bus.hash_in;
            state    <= S_CHECK;
          end else if (timeout_tc) begin
            retries <= sat_inc8(retries);
            state   <= S_ISSUE;
          end
        end
        S_CHECK: begin
          attempts <= attempts_next;
          if (hash_reg < target_reg) begin
            found_nonce <= cur;
            fin         <= 1'b1;
            state       <= S_DONE;
          end else if (attempts_next == limit_reg) begin
            // limit 0 matches only after attempts wraps: full 2^NONCE_W range
            exhausted <= 1'b1;
            state     <= S_DONE;
          end else begin
            cur   <= cur + NONCE_W'(1);
            state <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy            = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign bus.nonce_valid = (state == S_ISSUE);
  assign bus.nonce       = cur;

endmodule

// File: tb/tb_nonce_sequencer.sv
module tb_nonce_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] seed;
  logic [31:0] limit;
  logic [23:0] target;
  logic        busy;
  logic        fin;
  logic        exhausted;
  logic [31:0] found_nonce;
  logic [31:0] attempts;
  logic [7:0]  retries;

  int n_cmp = 0;
  int n_bad = 0;

  nonce_sequencer_if #(.NONCE_W(32), .HASH_W(24)) bus ();

  nonce_sequencer #(.NONCE_W(32), .HASH_W(24), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .limit      (limit),
    .target     (target),
    .bus        (bus),
    .busy       (busy),
    .fin        (fin),
    .exhausted  (exhausted),
    .found_nonce(found_nonce),
    .attempts   (attempts),
    .retries    (retries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] limit;
    logic [23:0] target;
    int          hit_at;       // attempt (1-based) answered with hit_hash; 0 = never
    logic [23:0] hit_hash;
    int          delay;        // WAIT cycles before hash_valid
    int          ready_delay;  // ISSUE cycles with hash_ready low
    bit          timeout_first;
    bit          exp_fin;
    bit          exp_exh;
    logic [31:0] exp_found;
    logic [31:0] exp_att;
    logic [7:0]  exp_retries;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_search(input vec_t v);
    logic [31:0] e;
    int          n;
    bit          done;
    bus.hash_ready = 1'b0;
    start  = 1'b1;
    seed   = v.seed;
    limit  = v.limit;
    target = v.target;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      e = v.seed + 32'(i);
      chk("nonce_valid_issue", {31'd0, bus.nonce_valid}, 32'd1);
      chk("nonce_value", bus.nonce, e);
      for (int j = 0; j < v.ready_delay; j++) begin
        if (j == 0) begin
          bus.hash_valid = 1'b1;   // stray result in ISSUE must be ignored
          bus.hash_in    = 24'h0;
        end
        tick();
        bus.hash_valid = 1'b0;
        chk("bp_nonce_valid", {31'd0, bus.nonce_valid}, 32'd1);
        chk("bp_nonce_stable", bus.nonce, e);
      end
      bus.hash_ready = 1'b1;
      tick();
      bus.hash_ready = 1'b0;
      chk("wait_nonce_valid", {31'd0, bus.nonce_valid}, 32'd0);
      if (v.timeout_first && i == 0) begin
        n = 0;
        while (!bus.nonce_valid && n < 200) begin
          tick();
          n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
        chk("reissue_nonce", bus.nonce, e);
        chk("retries_after_timeout", {24'd0, retries}, 32'd1);
        bus.hash_ready = 1'b1;
        tick();
        bus.hash_ready = 1'b0;
      end
      for (int d = 0; d < v.delay; d++) begin
        if (d == 0) begin
          start = 1'b1;            // start while busy must be ignored
          seed  = ~v.seed;
        end
        tick();
        start = 1'b0;
        seed  = v.seed;
      end
      bus.hash_valid = 1'b1;
      bus.hash_in    = (i + 1 == v.hit_at) ? v.hit_hash : 24'hFFFFFF;
      tick();
      bus.hash_valid = 1'b0;
      tick();
      if (!busy) done = 1'b1;
    end
    chk("search_ended", {31'd0, done}, 32'd1);
    chk("fin", {31'd0, fin}, {31'd0, v.exp_fin});
    chk("exhausted", {31'd0, exhausted}, {31'd0, v.exp_exh});
    chk("attempts", attempts, v.exp_att);
    chk("retries", {24'd0, retries}, {24'd0, v.exp_retries});
    if (v.exp_fin) chk("found_nonce", found_nonce, v.exp_found);
    tick();
    chk("idle_nonce_valid", {31'd0, bus.nonce_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("fin_hold", {31'd0, fin}, {31'd0, v.exp_fin});
    chk("exhausted_hold", {31'd0, exhausted}, {31'd0, v.exp_exh});
  endtask

  initial begin
    vec_t rv;
    //            seed          limit  target     hit hash       dly rdy to  fin exh found         att    rty
    vecs[0] = '{32'h10,       32'd8, 24'h000100, 1, 24'h0000FF, 3, 0, 0, 1, 0, 32'h10,       32'd1, 8'd0};
    vecs[1] = '{32'h20,       32'd4, 24'h000010, 0, 24'h000000, 1, 0, 0, 0, 1, 32'h0,        32'd4, 8'd0};
    vecs[2] = '{32'hFFFFFFFE, 32'd4, 24'h000100, 4, 24'h000050, 0, 0, 0, 1, 0, 32'h00000001, 32'd4, 8'd0};
    vecs[3] = '{32'h7,        32'd2, 24'h000000, 1, 24'h000000, 2, 0, 0, 0, 1, 32'h0,        32'd2, 8'd0};
    vecs[4] = '{32'h100,      32'd5, 24'h800000, 3, 24'h7FFFFF, 1, 1, 0, 1, 0, 32'h102,      32'd3, 8'd0};
    vecs[5] = '{32'h40,       32'd2, 24'h000123, 1, 24'h000123, 0, 0, 0, 0, 1, 32'h0,        32'd2, 8'd0};
    vecs[6] = '{32'h9,        32'd1, 24'h000005, 0, 24'h000000, 1, 0, 0, 0, 1, 32'h0,        32'd1, 8'd0};
    vecs[7] = '{32'h30,       32'd3, 24'h000010, 2, 24'h00000F, 2, 10, 0, 1, 0, 32'h31,      32'd2, 8'd0};
    vecs[8] = '{32'h5,        32'd4, 24'h000100, 1, 24'h000000, 1, 0, 1, 1, 0, 32'h5,        32'd1, 8'd1};

    reset          = 1'b1;
    start          = 1'b0;
    seed           = '0;
    limit          = '0;
    target         = '0;
    bus.hash_ready = 1'b0;
    bus.hash_valid = 1'b0;
    bus.hash_in    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_nonce_valid", {31'd0, bus.nonce_valid}, 32'd0);
    chk("rst_fin", {31'd0, fin}, 32'd0);
    chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
    chk("rst_attempts", attempts, 32'd0);
    chk("rst_found", found_nonce, 32'd0);
    chk("rst_retries", {24'd0, retries}, 32'd0);
    chk("rst_nonce", bus.nonce, 32'd0);

    // stray hash_valid in IDLE must not start anything
    bus.hash_valid = 1'b1;
    tick();
    bus.hash_valid = 1'b0;
    chk("idle_hv_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 9; k++) run_search(vecs[k]);

    // reset in WAIT with start on the same edge
    start  = 1'b1;
    seed   = 32'h50;
    limit  = 32'd4;
    target = 24'h0;
    tick();
    start = 1'b0;
    bus.hash_ready = 1'b1;
    tick();
    bus.hash_ready = 1'b0;
    tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    seed  = 32'h77;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_nonce_valid", {31'd0, bus.nonce_valid}, 32'd0);
    chk("midrst_attempts", attempts, 32'd0);
    chk("midrst_fin", {31'd0, fin}, 32'd0);
    chk("midrst_found", found_nonce, 32'd0);
    chk("midrst_nonce", bus.nonce, 32'd0);
    tick();
    chk("midrst_still_idle", {31'd0, busy}, 32'd0);

    rv = '{32'h60, 32'd2, 24'h000010, 2, 24'h000001, 1, 0, 0, 1, 0, 32'h61, 32'd2, 8'd0};
    run_search(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
